// File: rtl/icp_pkg.sv
// Shared definitions for the intcode core, its memory loader and the bench model.
package icp_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTE_SHIFT = 2;

  localparam logic [31:0] OP_ADD  = 32'd1;
  localparam logic [31:0] OP_MUL  = 32'd2;
  localparam logic [31:0] OP_HALT = 32'd99;
  localparam logic [31:0] OP_OUT  = 32'd100;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2
  } icp_state_e;

  // Misaligned or beyond the end of a memory of 'depth' words.
  function automatic logic is_bad_addr(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || ((addr >> BYTE_SHIFT) >= $unsigned(depth));
  endfunction

endpackage

// File: rtl/icp_mem_loader_if.sv
// Host load/dump streams, core memory ports and status of the loader.
interface icp_mem_loader_if;
  import icp_pkg::*;

  logic              i_load_valid;
  logic              o_load_ready;
  logic [DATA_W-1:0] i_load_data;
  logic              i_load_last;
  logic              i_dump_start;
  logic              o_dump_valid;
  logic              i_dump_ready;
  logic [DATA_W-1:0] o_dump_data;
  logic              o_dump_last;
  logic              o_core_rst;
  logic              i_read_en;
  logic [31:0]       i_read_addr;
  logic [DATA_W-1:0] o_data_in;
  logic              i_write_en;
  logic [31:0]       i_write_addr;
  logic [DATA_W-1:0] i_data_out;
  logic              o_fault;
  logic [31:0]       o_fault_addr;
  logic [1:0]        o_state;

  modport slave (
    input  i_load_valid, i_load_data, i_load_last, i_dump_start, i_dump_ready,
    input  i_read_en, i_read_addr, i_write_en, i_write_addr, i_data_out,
    output o_load_ready, o_dump_valid, o_dump_data, o_dump_last, o_core_rst,
    output o_data_in, o_fault, o_fault_addr, o_state
  );

  modport master (
    output i_load_valid, i_load_data, i_load_last, i_dump_start, i_dump_ready,
    output i_read_en, i_read_addr, i_write_en, i_write_addr, i_data_out,
    input  o_load_ready, o_dump_valid, o_dump_data, o_dump_last, o_core_rst,
    input  o_data_in, o_fault, o_fault_addr, o_state
  );

endinterface

// File: rtl/icp_word_ram.sv
// Word RAM: one synchronous write port, one asynchronous read port.
module icp_word_ram
  import icp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  // Write commit; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icp_mem_loader.sv
// Program memory for the intcode core: host loads an image, releases the core,
// and on request freezes the core and streams the image back out.
module icp_mem_loader
  import icp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  icp_mem_loader_if.slave io_bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [31:0]       OVF_ADDR = 32'(DEPTH_WORDS * 4);

  icp_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_load_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic [ADDR_W:0]   r_dump_ptr;
  logic              r_load_ready;
  logic              r_core_rst;
  logic              r_dump_valid;
  logic              r_dump_last;
  logic [DATA_W-1:0] r_dump_data;
  logic              r_fault;
  logic [31:0]       r_fault_addr;

  logic              w_load_fire, w_load_end, w_load_ovf;
  logic              w_run, w_dump_fire, w_dump_end;
  logic              w_rd_bad, w_wr_bad, w_rd_fault, w_wr_fault;
  logic              w_core_rd_ok, w_core_wr_ok;
  logic              w_fault_hit;
  logic [31:0]       w_fault_addr;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr, w_ram_raddr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;

  assign w_run       = (r_state == S_RUN);
  assign w_load_fire = (r_state == S_LOAD) && io_bus.i_load_valid && r_load_ready;
  assign w_load_end  = w_load_fire && (io_bus.i_load_last || (r_load_ptr == LAST_IDX));
  assign w_load_ovf  = w_load_fire && !io_bus.i_load_last && (r_load_ptr == LAST_IDX);
  assign w_dump_fire = (r_state == S_DUMP) && r_dump_valid && io_bus.i_dump_ready;
  assign w_dump_end  = w_dump_fire && r_dump_last;

  assign w_rd_bad     = is_bad_addr(io_bus.i_read_addr, DEPTH_WORDS);
  assign w_wr_bad     = is_bad_addr(io_bus.i_write_addr, DEPTH_WORDS);
  assign w_rd_fault   = w_run && io_bus.i_read_en && w_rd_bad;
  assign w_wr_fault   = w_run && io_bus.i_write_en && w_wr_bad;
  // The read port is handed to the dump path on the dump request edge so word 0 is ready.
  assign w_core_rd_ok = w_run && !io_bus.i_dump_start && io_bus.i_read_en && !w_rd_bad;
  assign w_core_wr_ok = w_run && io_bus.i_write_en && !w_wr_bad;

  icp_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_load_end) w_state_nxt = S_RUN;
        else            w_state_nxt = S_LOAD;
      end
      S_RUN: begin
        if (io_bus.i_dump_start) w_state_nxt = S_DUMP;
        else                     w_state_nxt = S_RUN;
      end
      S_DUMP: begin
        if (w_dump_end) w_state_nxt = S_LOAD;
        else            w_state_nxt = S_DUMP;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // RAM port muxing per state.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_load_ptr;
    w_ram_wdata = io_bus.i_load_data;
    w_ram_raddr = r_dump_ptr[ADDR_W-1:0];
    case (r_state)
      S_LOAD: begin
        w_ram_we = w_load_fire;
      end
      S_RUN: begin
        w_ram_we    = w_core_wr_ok;
        w_ram_waddr = io_bus.i_write_addr[ADDR_W+1:BYTE_SHIFT];
        w_ram_wdata = io_bus.i_data_out;
        if (io_bus.i_dump_start) w_ram_raddr = r_dump_ptr[ADDR_W-1:0];
        else                     w_ram_raddr = io_bus.i_read_addr[ADDR_W+1:BYTE_SHIFT];
      end
      S_DUMP: begin
        w_ram_we = 1'b0;
      end
      default: begin
        w_ram_we = 1'b0;
      end
    endcase
  end

  // Load, run and dump sequencing registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load_ptr   <= '0;
      r_word_count <= '0;
      r_dump_ptr   <= '0;
      r_load_ready <= 1'b1;
      r_core_rst   <= 1'b1;
      r_dump_valid <= 1'b0;
      r_dump_last  <= 1'b0;
      r_dump_data  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_fire) begin
            r_load_ptr <= r_load_ptr + PTR_ONE;
            if (w_load_end) begin
              r_word_count <= {1'b0, r_load_ptr} + CNT_ONE;
              r_load_ready <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (io_bus.i_dump_start) begin
            r_core_rst   <= 1'b1;
            r_dump_valid <= 1'b1;
            r_dump_data  <= w_ram_rdata;
            r_dump_last  <= (r_word_count == CNT_ONE);
            r_dump_ptr   <= CNT_ONE;
          end else begin
            r_core_rst <= 1'b0;
          end
        end
        S_DUMP: begin
          if (w_dump_fire) begin
            if (r_dump_last) begin
              r_dump_valid <= 1'b0;
              r_dump_last  <= 1'b0;
              r_dump_ptr   <= '0;
              r_load_ptr   <= '0;
              r_load_ready <= 1'b1;
            end else begin
              r_dump_data <= w_ram_rdata;
              r_dump_last <= (r_dump_ptr == r_word_count - CNT_ONE);
              r_dump_ptr  <= r_dump_ptr + CNT_ONE;
            end
          end
        end
        default: begin
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  // Fault source priority: load overflow, then core read, then core write.
  always_comb begin
    w_fault_hit  = 1'b1;
    w_fault_addr = 32'd0;
    if (w_load_ovf) begin
      w_fault_addr = OVF_ADDR;
    end else if (w_rd_fault) begin
      w_fault_addr = io_bus.i_read_addr;
    end else if (w_wr_fault) begin
      w_fault_addr = io_bus.i_write_addr;
    end else begin
      w_fault_hit = 1'b0;
    end
  end

  // Sticky fault; the address is only captured while no fault is pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault      <= 1'b0;
      r_fault_addr <= 32'd0;
    end else if (w_dump_end) begin
      r_fault <= 1'b0;
    end else if (!r_fault && w_fault_hit) begin
      r_fault      <= 1'b1;
      r_fault_addr <= w_fault_addr;
    end
  end

  assign io_bus.o_load_ready = r_load_ready;
  assign io_bus.o_core_rst   = r_core_rst;
  assign io_bus.o_dump_valid = r_dump_valid;
  assign io_bus.o_dump_data  = r_dump_data;
  assign io_bus.o_dump_last  = r_dump_last;
  assign io_bus.o_fault      = r_fault;
  assign io_bus.o_fault_addr = r_fault_addr;
  assign io_bus.o_state      = r_state;
  assign io_bus.o_data_in    = w_core_rd_ok ? w_ram_rdata : 32'd0;

endmodule
